if_id_stage: RTL and testbench



---
 rtl/if_id_pkg.sv | 41 ++++
 rtl/if_id_stage_sat_counter.sv | 37 +++
 rtl/if_id_stage.sv | 126 ++++++++++++
 tb/tb_if_id_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_id_pkg
// Description : Shared definitions for the IF/ID pipeline stage: default
//               widths, the NOP encoding, the pipeline entry record and the
//               occupancy encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_pkg;

    localparam int c_INSTR_W_DEF = 32;
    localparam int c_PC_W_DEF    = 32;

    // addi x0, x0, 0 - the canonical RISC-V bubble
    localparam logic [c_INSTR_W_DEF-1:0] c_NOP_INSTR = 32'h0000_0013;

    // One pipeline entry at the default widths
    typedef struct packed {
        logic [c_PC_W_DEF-1:0]    pc;
        logic [c_INSTR_W_DEF-1:0] instr;
    } entry_t;

    // Occupancy encoding: number of valid entries held
    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    function automatic logic [1:0] occ_count(input logic main_valid, input logic skid_valid);
        logic [1:0] occ;
        occ = c_OCC_EMPTY;
        if (main_valid && skid_valid) begin
            occ = c_OCC_FULL;
        end else if (main_valid || skid_valid) begin
            occ = c_OCC_ONE;
        end
        return occ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_stage_sat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at its maximum value instead of
//               wrapping. Updates on the falling clock edge.
// Ports       : clk   - clock (falling edge active)
//               rst_n - asynchronous active-low reset, clears the count
//               inc   - count one event this cycle
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : IF/ID pipeline stage with valid/ready handshake, a two-entry
//               (main + skid) buffer, hold, flush-to-NOP and saturating
//               stall / flush performance counters. State changes on the
//               falling clock edge.
// Ports       : clk, rst_n                 - clock (negedge), async low reset
//               in_valid/in_ready          - fetch-side handshake
//               in_instr/in_pc             - fetched instruction and its PC
//               hold                       - freeze all entries
//               flush                      - squash all entries
//               out_valid/out_ready        - decode-side handshake
//               out_instr/out_pc           - instruction to decode (NOP/0 if empty)
//               occupancy                  - valid entries held (0..2)
//               stall_cnt/flush_cnt        - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = c_INSTR_W_DEF,
    parameter int                 PC_W      = c_PC_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = c_NOP_INSTR,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               hold,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    // Entry record at the instance widths
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } stage_entry_t;

    logic         r_m_valid;
    logic         r_s_valid;
    stage_entry_t r_main;
    stage_entry_t r_skid;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_stall_inc;
    logic w_flush_inc;
    logic [1:0] w_occupancy;

    // rst_n gates in_ready so fetch never sees acceptance while in reset
    assign w_in_ready  = rst_n && !r_s_valid && !hold && !flush;
    assign w_out_valid = r_m_valid && !flush;
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && out_ready && !hold;
    assign w_occupancy = occ_count(r_m_valid, r_s_valid);

    // Hold only counts when not overridden by flush; out_valid is already
    // forced low by flush, so the backpressure term needs no extra gating.
    assign w_stall_inc = (hold && !flush) || (w_out_valid && !out_ready);
    assign w_flush_inc = flush && (w_occupancy != c_OCC_EMPTY);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_main    <= '0;
            r_skid    <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!hold) begin
            if (!r_s_valid) begin
                if (w_in_fire && (!r_m_valid || w_out_fire)) begin
                    r_main    <= '{pc: in_pc, instr: in_instr};
                    r_m_valid <= 1'b1;
                end else if (w_in_fire) begin
                    // Decode is stalled: park the new instruction in the skid
                    r_skid    <= '{pc: in_pc, instr: in_instr};
                    r_s_valid <= 1'b1;
                end else if (w_out_fire) begin
                    r_m_valid <= 1'b0;
                end
            end else if (w_out_fire) begin
                // in_ready is low while the skid is full, so no new input here
                r_main    <= r_skid;
                r_s_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_instr = r_m_valid ? r_main.instr : NOP_INSTR;
    assign out_pc    = r_m_valid ? r_main.pc : '0;
    assign occupancy = w_occupancy;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage
// Description : Self-checking bench for if_id_stage. Two instances (16-bit
//               and 4-bit counters) share one stimulus; a queue-based model
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;
    import if_id_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        hold;
    logic        flush;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_instr_a, out_pc_a, out_instr_b, out_pc_b;
    logic [1:0]  occ_a, occ_b;
    logic [15:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    always #5 clk = ~clk;

    if_id_stage #(.CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .in_pc(in_pc), .hold(hold), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(out_instr_a),
        .out_pc(out_pc_a), .occupancy(occ_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    if_id_stage #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(in_pc), .hold(hold), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
        .out_pc(out_pc_b), .occupancy(occ_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    // ---------------- behavioural model ----------------
    entry_t q[$];
    int     stall_raw;
    int     flush_raw;
    logic [31:0] nxt_pc;
    logic [31:0] pend_instr;
    int     n_checks = 0;
    int     n_fail   = 0;
    int     max_occ;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int raw, input int maxv);
        return (raw > maxv) ? maxv : raw;
    endfunction

    // Compare every output of both instances against the model's prediction
    task automatic check_outputs();
        int          occ;
        logic        e_ir, e_ov;
        logic [31:0] e_instr, e_pc;
        occ     = q.size();
        e_ir    = rst_n && (occ < 2) && !hold && !flush;
        e_ov    = (occ > 0) && !flush;
        e_instr = (occ > 0) ? q[0].instr : 32'h0000_0013;
        e_pc    = (occ > 0) ? q[0].pc : 32'h0;
        cmp("in_ready",    64'(in_ready_a),  64'(e_ir));
        cmp("out_valid",   64'(out_valid_a), 64'(e_ov));
        cmp("out_instr",   64'(out_instr_a), 64'(e_instr));
        cmp("out_pc",      64'(out_pc_a),    64'(e_pc));
        cmp("occupancy",   64'(occ_a),       64'(occ));
        cmp("stall_cnt16", 64'(stall_a),     64'(sat(stall_raw, 65535)));
        cmp("flush_cnt16", 64'(flush_a),     64'(sat(flush_raw, 65535)));
        cmp("stall_cnt4",  64'(stall_b),     64'(sat(stall_raw, 15)));
        cmp("flush_cnt4",  64'(flush_b),     64'(sat(flush_raw, 15)));
        cmp("out_pc4",     64'(out_pc_b),    64'(e_pc));
        if (int'(occ_a) > max_occ) max_occ = int'(occ_a);
    endtask

    task automatic model_step();
        logic e_ir, e_ov, fire_in, fire_out;
        e_ir     = rst_n && (q.size() < 2) && !hold && !flush;
        e_ov     = (q.size() > 0) && !flush;
        fire_in  = in_valid && e_ir;
        fire_out = e_ov && out_ready && !hold;
        if (flush) begin
            if (q.size() != 0) flush_raw++;
            q.delete();
        end else begin
            if (hold || (e_ov && !out_ready)) stall_raw++;
            if (fire_out) void'(q.pop_front());
            if (fire_in) q.push_back('{pc: in_pc, instr: in_instr});
        end
        if (fire_in) begin
            nxt_pc     = nxt_pc + 32'd4;
            pend_instr = $urandom;
        end
    endtask

    // One clock: drive at posedge, check mid-cycle, model the falling edge
    task automatic cycle(input logic r, input logic v, input logic h, input logic f, input logic rdy);
        @(posedge clk);
        rst_n     = r;
        in_valid  = v;
        hold      = h;
        flush     = f;
        out_ready = rdy;
        in_pc     = nxt_pc;
        in_instr  = pend_instr;
        if (!r) begin
            q.delete();
            stall_raw = 0;
            flush_raw = 0;
        end
        #1;
        check_outputs();
        if (r) model_step();
    endtask

    // Land just after the falling edge to look at freshly updated state
    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        nxt_pc = 32'h0; pend_instr = 32'hA000_0001;
        stall_raw = 0; flush_raw = 0; max_occ = 0;

        // ---- reset state ----
        do_reset();
        peek();
        cmp("rst_out_instr", 64'(out_instr_a), 64'h13);
        cmp("rst_occ", 64'(occ_a), 64'd0);

        // ---- streaming: 8 instructions, decode always ready ----
        nxt_pc = 32'h0; max_occ = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("stream_max_occ", 64'(max_occ), 64'd1);
        cmp("stream_stall", 64'(stall_a), 64'd0);
        cmp("stream_next_pc", 64'(nxt_pc), 64'h20);

        // ---- backpressure ----
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        peek();
        cmp("bp_stall", 64'(stall_a), 64'd3);
        cmp("bp_occ", 64'(occ_a), 64'd2);
        cmp("bp_in_ready", 64'(in_ready_a), 64'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // ---- flush with occupancy 2 and input present ----
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        peek();
        cmp("flush_occ", 64'(occ_a), 64'd0);
        cmp("flush_nop", 64'(out_instr_a), 64'h13);
        cmp("flush_cnt", 64'(flush_a), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        peek();
        cmp("flush_empty_cnt", 64'(flush_a), 64'd1);

        // ---- hold 4 cycles, then hold + flush ----
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        peek();
        cmp("hold_stall", 64'(stall_a), 64'd4);
        cmp("hold_occ", 64'(occ_a), 64'd1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        peek();
        cmp("holdflush_occ", 64'(occ_a), 64'd0);
        cmp("holdflush_stall", 64'(stall_a), 64'd4);

        // ---- saturation of the 4-bit counter ----
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        peek();
        cmp("sat_stall4", 64'(stall_b), 64'd15);
        cmp("sat_stall16", 64'(stall_a), 64'd20);

        // ---- mid-run reset with occupancy 2 ----
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("mrst_valid", 64'(out_valid_a), 64'd0);
        cmp("mrst_instr", 64'(out_instr_a), 64'h13);
        cmp("mrst_occ", 64'(occ_a), 64'd0);
        cmp("mrst_stall", 64'(stall_a), 64'd0);
        cmp("mrst_in_ready", 64'(in_ready_a), 64'd0);
        q.delete(); stall_raw = 0; flush_raw = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        nxt_pc = 32'h0000_0100;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        peek();
        cmp("mrst_first_valid", 64'(out_valid_a), 64'd1);
        cmp("mrst_first_pc", 64'(out_pc_a), 64'h100);

        // ---- randomized traffic ----
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
